// File: rtl/intr_controller.sv
// intr_controller: edge-latched, maskable priority interrupt controller with Intr/Inta/Eret handshake
module intr_controller #(
    parameter int             N          = 8,
    parameter int             IDW        = 4,
    parameter logic [N-1:0]   RESET_MASK = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_irq,
    input  logic             i_mask_we,
    input  logic [N-1:0]     i_mask_wdata,
    input  logic             i_inta,
    input  logic             i_eret,
    output logic             o_intr,
    output logic [IDW-1:0]   o_vector,
    output logic             o_vector_valid,
    output logic [N-1:0]     o_mask,
    output logic [N-1:0]     o_pending,
    output logic [N-1:0]     o_in_service
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]     r_state;
    logic [N-1:0]   r_irq_q;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   r_mask;
    logic [N-1:0]   r_in_service;
    logic           r_intr;
    logic           r_vector_valid;
    logic [IDW-1:0] r_vector;

    logic [N-1:0]   w_rise;
    logic [N-1:0]   w_req;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_win_onehot;
    logic [IDW-1:0] w_win_idx;
    logic           w_ack;

    assign w_rise = i_irq & ~r_irq_q;
    assign w_req  = r_pending & ~r_mask;
    assign w_ack  = (r_state == S_REQ) && i_inta;
    assign w_clr  = w_ack ? w_win_onehot : '0;

    // lowest-index requesting source wins; scanning downward leaves the lowest hit last
    always_comb begin
        w_win_idx    = '0;
        w_win_onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_idx       = IDW'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // edge capture, pending set/clear (a fresh edge beats the acknowledge clear) and mask register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_mask    <= RESET_MASK;
        end else begin
            r_irq_q   <= i_irq;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (i_mask_we) r_mask <= i_mask_wdata;
        end
    end

    // request / acknowledge / service handshake; an empty request at Inta yields the spurious vector
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_intr         <= 1'b0;
            r_vector       <= '0;
            r_vector_valid <= 1'b0;
            r_in_service   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_intr  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_inta) begin
                        r_vector       <= (|w_req) ? w_win_idx : '1;
                        r_in_service   <= w_win_onehot;
                        r_intr         <= 1'b0;
                        r_vector_valid <= 1'b1;
                        r_state        <= S_SERVICE;
                    end else if (!(|w_req)) begin
                        r_intr  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (i_eret) begin
                        r_in_service   <= '0;
                        r_vector_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_intr  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_intr         = r_intr;
    assign o_vector       = r_vector;
    assign o_vector_valid = r_vector_valid;
    assign o_mask         = r_mask;
    assign o_pending      = r_pending;
    assign o_in_service   = r_in_service;
endmodule

// File: tb/tb_intr_controller.sv
// tb_intr_controller: directed vector table plus hand sequences for intr_controller
module tb_intr_controller;
    localparam logic [7:0] RM = 8'h80;

    logic       clk;
    logic       rst;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       inta;
    logic       eret;
    logic       intr;
    logic [3:0] vector;
    logic       vector_valid;
    logic [7:0] mask;
    logic [7:0] pending;
    logic [7:0] in_service;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       we;
        logic [7:0] wd;
        logic       inta;
        logic       eret;
        int         n;
        logic       e_intr;
        logic [3:0] e_vec;
        logic       e_vv;
        logic [7:0] e_mask;
        logic [7:0] e_pend;
        logic [7:0] e_is;
    } vec_t;

    vec_t tbl[$];

    intr_controller #(.N(8), .IDW(4), .RESET_MASK(RM)) dut (
        .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_mask_we(mask_we), .i_mask_wdata(mask_wdata),
        .i_inta(inta), .i_eret(eret), .o_intr(intr), .o_vector(vector), .o_vector_valid(vector_valid),
        .o_mask(mask), .o_pending(pending), .o_in_service(in_service)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", tag, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        for (int r = 0; r < v.n; r++) begin
            @(negedge clk);
            rst = v.rst; irq = v.irq; mask_we = v.we; mask_wdata = v.wd; inta = v.inta; eret = v.eret;
            @(posedge clk);
            #1;
            chk("intr", idx, {7'd0, intr}, {7'd0, v.e_intr});
            chk("vector", idx, {4'd0, vector}, {4'd0, v.e_vec});
            chk("vector_valid", idx, {7'd0, vector_valid}, {7'd0, v.e_vv});
            chk("mask", idx, mask, v.e_mask);
            chk("pending", idx, pending, v.e_pend);
            chk("in_service", idx, in_service, v.e_is);
        end
    endtask

    task automatic step(input int idx, input logic r, input logic [7:0] q, input logic we, input logic [7:0] wd,
                        input logic a, input logic e, input logic xi, input logic [3:0] xv, input logic xvv,
                        input logic [7:0] xm, input logic [7:0] xp, input logic [7:0] xs);
        vec_t v;
        v = '{r, q, we, wd, a, e, 1, xi, xv, xvv, xm, xp, xs};
        apply(v, idx);
    endtask

    initial begin
        rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; inta = 1'b0; eret = 1'b0;
        //                rst irq    we wd     ia er n   intr vec  vv mask   pend   is
        tbl.push_back('{1, 8'h00, 0, 8'h00, 0, 0, 2,  0, 4'h0, 0, RM,    8'h00, 8'h00});
        tbl.push_back('{0, 8'h08, 0, 8'h00, 0, 0, 1,  0, 4'h0, 0, RM,    8'h08, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  1, 4'h0, 0, RM,    8'h08, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 1,  0, 4'h3, 1, RM,    8'h00, 8'h08});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  0, 4'h3, 1, RM,    8'h00, 8'h08});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 1,  0, 4'h3, 0, RM,    8'h00, 8'h00});
        tbl.push_back('{0, 8'h20, 0, 8'h00, 0, 0, 1,  0, 4'h3, 0, RM,    8'h20, 8'h00});
        tbl.push_back('{0, 8'h20, 0, 8'h00, 0, 0, 1,  1, 4'h3, 0, RM,    8'h20, 8'h00});
        tbl.push_back('{0, 8'h22, 0, 8'h00, 0, 0, 1,  1, 4'h3, 0, RM,    8'h22, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 1,  0, 4'h1, 1, RM,    8'h20, 8'h02});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 1,  0, 4'h1, 0, RM,    8'h20, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  1, 4'h1, 0, RM,    8'h20, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 1,  0, 4'h5, 1, RM,    8'h00, 8'h20});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 1,  0, 4'h5, 0, RM,    8'h00, 8'h00});
        tbl.push_back('{0, 8'h00, 1, 8'h04, 0, 0, 1,  0, 4'h5, 0, 8'h04, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h04, 0, 8'h00, 0, 0, 1,  0, 4'h5, 0, 8'h04, 8'h04, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 10, 0, 4'h5, 0, 8'h04, 8'h04, 8'h00});
        tbl.push_back('{0, 8'h00, 1, 8'h00, 0, 0, 1,  0, 4'h5, 0, 8'h00, 8'h04, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  1, 4'h5, 0, 8'h00, 8'h04, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 1,  0, 4'h2, 1, 8'h00, 8'h00, 8'h04});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 1,  0, 4'h2, 0, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h01, 0, 8'h00, 0, 0, 1,  0, 4'h2, 0, 8'h00, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  1, 4'h2, 0, 8'h00, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 1, 8'h01, 0, 0, 1,  1, 4'h2, 0, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 2,  0, 4'h2, 0, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 1, 8'h00, 0, 0, 1,  0, 4'h2, 0, 8'h00, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  1, 4'h2, 0, 8'h00, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 1, 8'h01, 0, 0, 1,  1, 4'h2, 0, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 1,  0, 4'hF, 1, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 1,  0, 4'hF, 0, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 1,  0, 4'hF, 0, 8'h01, 8'h01, 8'h00});
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // reset taken in SERVICE with Irq[4] held high across it
        step(100, 0, 8'h00, 1, 8'h00, 0, 0, 0, 4'hF, 0, 8'h00, 8'h01, 8'h00);
        step(101, 0, 8'h00, 0, 8'h00, 0, 0, 1, 4'hF, 0, 8'h00, 8'h01, 8'h00);
        step(102, 0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 1, 8'h00, 8'h00, 8'h01);
        step(103, 0, 8'h30, 0, 8'h00, 0, 0, 0, 4'h0, 1, 8'h00, 8'h30, 8'h01);
        step(104, 0, 8'h10, 0, 8'h00, 0, 0, 0, 4'h0, 1, 8'h00, 8'h30, 8'h01);
        step(105, 1, 8'h10, 0, 8'h00, 0, 0, 0, 4'h0, 0, RM,    8'h00, 8'h00);
        step(106, 0, 8'h10, 0, 8'h00, 0, 0, 0, 4'h0, 0, RM,    8'h10, 8'h00);
        step(107, 0, 8'h10, 0, 8'h00, 0, 0, 1, 4'h0, 0, RM,    8'h10, 8'h00);

        // new edge in the acknowledge cycle re-pends the same source; stray Inta/Eret ignored
        step(200, 0, 8'h00, 0, 8'h00, 0, 0, 1, 4'h0, 0, RM,    8'h10, 8'h00);
        step(201, 0, 8'h10, 0, 8'h00, 1, 0, 0, 4'h4, 1, RM,    8'h10, 8'h10);
        step(202, 0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h4, 1, RM,    8'h10, 8'h10);
        step(203, 0, 8'h00, 0, 8'h00, 0, 1, 0, 4'h4, 0, RM,    8'h10, 8'h00);
        step(204, 0, 8'h00, 0, 8'h00, 0, 0, 1, 4'h4, 0, RM,    8'h10, 8'h00);
        step(205, 0, 8'h00, 0, 8'h00, 0, 1, 1, 4'h4, 0, RM,    8'h10, 8'h00);
        step(206, 0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h4, 1, RM,    8'h00, 8'h10);
        step(207, 0, 8'h00, 0, 8'h00, 0, 1, 0, 4'h4, 0, RM,    8'h00, 8'h00);
        step(208, 0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h4, 0, RM,    8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Priority interrupt controller in front of the exception/interrupt CPU core.
- Collects N external interrupt sources, latches rising edges as pending events, and applies a mask.
- Drives the core's single Intr request, then completes the Intr/Inta handshake by presenting the winning source's vector.
- Holds that source in-service until the core signals return-from-interrupt (Eret).

Parameters:
- N, 8, number of interrupt sources; index 0 = highest priority.
- IDW, 4, vector width; requires N <= 2^IDW - 1.
- RESET_MASK, 0 (N bits), mask value loaded at reset; 1 = source disabled.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous reset, active-high.
- Irq  in  N  interrupt sources, synchronous to Clk, rising-edge sensitive.
- Mask_we  in  1  mask register write enable.
- Mask_wdata  in  N  new mask value.
- Inta  in  1  interrupt acknowledge from CPU.
- Eret  in  1  return-from-interrupt / end-of-service from CPU.
- Intr  out  1  interrupt request to CPU, registered.
- Vector  out  IDW  acknowledged source index; all-ones = spurious.
- Vector_valid  out  1  high while in SERVICE.
- Mask  out  N  current mask register.
- Pending  out  N  current pending register.
- In_service  out  N  one-hot source being serviced; zero otherwise.

Behaviour:
- Reset, synchronous, overrides everything:
  - State = IDLE; Intr = 0; Vector = 0; Vector_valid = 0; Pending = 0; In_service = 0; Mask = RESET_MASK; irq_q = 0.
  - Consequence: an Irq line held high across reset produces one pending event on the first cycle after reset.
- Edge detect:
  - rise = Irq & ~irq_q; irq_q <= Irq every cycle.
  - Pending <= (Pending & ~clr) | rise.
  - If rise and clr hit the same bit in the same cycle, set wins (the new edge is a new event).
  - Masked sources still latch pending; they only don't request.
- Mask:
  - On Mask_we, Mask <= Mask_wdata in any state.
  - The new mask takes effect for request/arbitration from the next cycle.
  - Unmasking a pending source causes a request.
- req_vec = Pending & ~Mask.
- FSM, 3 states:
  - IDLE: if |req_vec, then Intr <= 1 and go to REQ (Intr rises 1 cycle after the pending bit is visible). Inta and Eret are ignored.
  - REQ: Intr held 1.
    - If req_vec == 0 and Inta == 0 (masked away), then Intr <= 0 and go to IDLE.
    - If Inta == 1: arbitrate req_vec in that cycle, lowest index wins (a higher-priority edge arriving during REQ overrides earlier ones).
      - Winner k: Vector <= k; clr[k] = 1; In_service <= 1<<k; Intr <= 0; Vector_valid <= 1; go to SERVICE.
      - If req_vec == 0 in the Inta cycle: Vector <= all-ones; no pending change; In_service = 0; Vector_valid <= 1; go to SERVICE (spurious, CPU still issues Eret).
    - Eret is ignored.
  - SERVICE: Intr = 0; new edges keep latching into Pending.
    - On Eret: In_service <= 0; Vector_valid <= 0; go to IDLE.
    - Vector holds its value until the next acknowledge.
    - Inta is ignored.
    - No nesting: a higher-priority event waits for Eret.
- Back-to-back: with further unmasked pending after Eret, the sequence is IDLE (1 cycle), then Intr high the following cycle.
- Inta/Eret are single-cycle pulses from the CPU. If either is held high, each cycle is evaluated independently under the rules above.

Test Plan:
- Reset, then pulse Irq[3] 1 cycle -> Pending = 0x08 next cycle; Intr = 1 one cycle later; Inta pulse -> Vector = 3, Pending = 0, In_service = 0x08, Intr = 0; Eret -> In_service = 0, Vector_valid = 0, state IDLE.
- Raise Irq[5], and while Intr = 1 and before Inta raise Irq[1]; then Inta -> Vector = 1, Pending = 0x20; after Eret, Intr reasserts 2 cycles later; second Inta -> Vector = 5.
- Mask_wdata = 0x04 with Mask_we, then edge on Irq[2] -> Pending = 0x04, Intr stays 0 for 10 cycles; write Mask = 0 -> Intr = 1 two cycles after the write.
- Irq[0] edge -> Intr = 1; write Mask = 0x01 before Inta -> Intr drops the cycle after the mask takes effect, FSM in IDLE, Pending = 0x01 retained.
- Same-cycle race: Inta asserted in the cycle the mask write removes the only request -> Vector = 4'hF, Vector_valid = 1, Pending unchanged; Eret returns to IDLE.
- Assert Rst while in SERVICE with Pending = 0x30 and Irq[4] held high -> all outputs cleared next cycle, Mask = RESET_MASK; after Rst drops, Pending = 0x10 and Intr = 1 follows.
